keypad_scan_debounce: RTL
=========================

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000, clocks per column scan step; legal range is 4 or more.
REQ-002 SHALL have parameter DEB_CNT, default 4, consecutive stable samples to accept a press or a release; legal range is 1 or more.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fil  input  4  keypad rows, active-low, pulled up, asynchronous to clk.
REQ-006 SHALL have port col  output  4  column drive, active-low one-hot.
REQ-007 SHALL have port key_code  output  4  hex code of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse per accepted press.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass fil through a 2-flop synchronizer; all row decisions use the synchronized value (rs).
REQ-011 SHALL run a prescaler counting 0..SCAN_DIV-1 and wrapping; "tick" is the cycle when the count equals SCAN_DIV-1.
REQ-012 SHALL sample rs only on ticks.
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE and PRESSED.
REQ-014 SHALL drive col with the active column index c: col = ~(1<<c).
REQ-015 SHALL change col only on a tick, in state SCAN, when no row is low; c advances 0->1->2->3->0.
REQ-016 SCAN: on a tick with rs != 4'hF, SHALL latch the pattern P=rs and the column c, clear the stable counter, go to DEBOUNCE, and hold col.
REQ-017 DEBOUNCE: on each tick, if rs==P SHALL increment the stable counter.
REQ-018 DEBOUNCE: on a tick with rs!=P, SHALL return to SCAN with the same column and zero the counter; no pulse.
REQ-019 DEBOUNCE: when the stable counter reaches DEB_CNT, in the same cycle SHALL register key_code, assert key_valid for exactly one clk, and enter PRESSED.
REQ-020 SHALL derive the row r as the lowest-index zero bit of P.
REQ-021 SHALL map (r,c) to key_code: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D, columns 0..3.
REQ-022 SHALL hold key_code until the next accepted press.
REQ-023 PRESSED: SHALL hold key_held=1 and col fixed.
REQ-024 PRESSED: on each tick with rs==4'hF SHALL increment the release counter; any tick with rs!=4'hF SHALL zero it.
REQ-025 PRESSED: when the release counter reaches DEB_CNT, SHALL clear key_held, advance c, and return to SCAN.
REQ-026 A continuously held key SHALL produce exactly one key_valid; there is no auto-repeat.
REQ-027 Second keys pressed while in PRESSED SHALL be ignored until release is accepted.
REQ-028 Press latency SHALL be (DEB_CNT+1) ticks from the first tick that sees the row low.

Reset
REQ-029 While rst is low, SHALL asynchronously force: state=SCAN, c=0, col=4'b1110, key_code=0, key_valid=0, key_held=0, all counters=0, synchronizer flops=4'hF.
REQ-030 Reset mid-debounce or mid-press SHALL discard the press; after release of rst, a still-held key SHALL be re-detected and produce a fresh key_valid.

Verification (SCAN_DIV=4, DEB_CNT=3, keypad model drives row low only while its column is driven)
REQ-031 Reset check: rst low -> col=1110, key_code=0, key_valid=0, key_held=0; after release, col steps 1110,1101,1011,0111,1110 every 4 clk.
REQ-032 Press '5' (r1,c1) held 200 clk -> exactly one key_valid with key_code=5, 4 ticks after detection; key_held=1; col stays 1101.
REQ-033 Bounce: row toggles on alternate ticks for 10 ticks, then is stable -> no pulse during the toggling; a single pulse after 3 stable ticks.
REQ-034 Release '5' -> key_held falls after 3 consecutive released ticks; col then goes to 1011 and scanning resumes; key_code stays 5.
REQ-035 Keys '1' and '7' pressed together (c0, rows 0 and 2) -> key_code=1; pressing '#' while '1' is held -> no pulse.
REQ-036 rst pulsed low during PRESSED with '9' still held -> outputs reset at once; after rst, key_valid pulses with key_code=9.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with tick-based debounce of both press and release.
// One column is driven low at a time; rows are sampled once per scan tick.
// A press produces a single key_valid pulse and key_held stays high until
// the release has been seen stable for DEB_CNT ticks.
module keypad_scan_debounce #(
  parameter int SCAN_DIV = 27000,
  parameter int DEB_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fil,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t          state_q;
  logic [3:0]      sync1_q, rs_q;
  logic [PW-1:0]   pre_q;
  logic [1:0]      c_q;
  logic [3:0]      pat_q;
  logic [DW-1:0]   stab_q, rel_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q, key_held_q;
  logic            tick;
  logic [DW-1:0]   stab_inc, rel_inc;

  // Lowest-index low row wins when several rows are down in one column.
  function automatic logic [1:0] low_row(input logic [3:0] p);
    if (!p[0])      low_row = 2'd0;
    else if (!p[1]) low_row = 2'd1;
    else if (!p[2]) low_row = 2'd2;
    else            low_row = 2'd3;
  endfunction

  // Keypad legend: * maps to E and # maps to F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick      = (pre_q == PW'(SCAN_DIV - 1));
  assign stab_inc  = stab_q + 1'b1;
  assign rel_inc   = rel_q + 1'b1;
  assign col       = ~(4'b0001 << c_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Two-flop synchronizer for the asynchronous row inputs; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= fil;
      rs_q    <= sync1_q;
    end
  end

  // Scan prescaler: wraps at SCAN_DIV-1, which is the tick cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= tick ? '0 : pre_q + 1'b1;
  end

  // Scan / debounce / pressed FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      c_q         <= 2'd0;
      pat_q       <= 4'hF;
      stab_q      <= '0;
      rel_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (rs_q != 4'hF) begin
              pat_q   <= rs_q;
              stab_q  <= '0;
              state_q <= DEBOUNCE;
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
          DEBOUNCE: begin
            if (rs_q != pat_q) begin
              // Unstable pattern: rescan the same column.
              stab_q  <= '0;
              state_q <= SCAN;
            end else if (stab_inc == DW'(DEB_CNT)) begin
              stab_q      <= '0;
              rel_q       <= '0;
              key_code_q  <= key_map(low_row(pat_q), c_q);
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
              state_q     <= PRESSED;
            end else begin
              stab_q <= stab_inc;
            end
          end
          PRESSED: begin
            // Column is frozen here, so other keys in other columns are invisible.
            if (rs_q != 4'hF) begin
              rel_q <= '0;
            end else if (rel_inc == DW'(DEB_CNT)) begin
              rel_q      <= '0;
              key_held_q <= 1'b0;
              c_q        <= c_q + 1'b1;
              state_q    <= SCAN;
            end else begin
              rel_q <= rel_inc;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

endmodule
